// File: rtl/soc_system_pio_in_debounced.sv
// Avalon-MM input PIO: per-bit 2-FF synchroniser, debounce filter, sticky edge
// capture with write-1-to-clear, and a maskable level interrupt.
// Read data is registered every clock (1-cycle latency). No wait states, no backpressure.
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   address, chipselect,  Avalon-MM slave: 0 = stable level (RO), 1 = synchronised
//   write, writedata,       raw level (RO), 2 = irq_mask (RW), 3 = edge_capture (W1C)
//   readdata
//   in_port               raw asynchronous pin inputs
//   irq                   |(edge_capture & irq_mask)
module soc_system_pio_in_debounced #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value on which a still-differing bit is finally accepted.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] upd;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [CW-1:0]    cnt     [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];
    logic [31:0]      rd_mux;
    logic             wr_en;

    // Upper write-data bits are architecturally ignored when WIDTH < 32.
    logic unused_wd;
    assign unused_wd = &{1'b0, writedata};

    assign wr_en = chipselect & write;

    // Debounce: a bit must disagree with its stable value for DEBOUNCE_CYCLES
    // consecutive clocks; any agreement in between restarts the count.
    always_comb begin
        stable_nxt = stable;
        upd        = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    upd[i]        = 1'b1;
                    stable_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // On an update the new stable value equals sync2, so sync2 gives direction.
    always_comb begin
        case (EDGE_TYPE)
            0:       edge_set = upd & sync2;
            1:       edge_set = upd & ~sync2;
            default: edge_set = upd;
        endcase
    end

    assign edge_clr = (wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: rd_mux = 32'(stable);
            2'd1: rd_mux = 32'(sync2);
            2'd2: rd_mux = 32'(irq_mask);
            2'd3: rd_mux = 32'(edge_capture);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1        <= '0;
            sync2        <= '0;
            stable       <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1  <= in_port;
            sync2  <= sync1;
            stable <= stable_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            // A new edge on the same clock as its W1C must not be lost: set wins.
            edge_capture <= (edge_capture & ~edge_clr) | edge_set;
            if (wr_en && (address == 2'd2)) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            readdata <= rd_mux;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_soc_system_pio_in_debounced.sv
module tb_soc_system_pio_in_debounced;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [1:0]  in_port;
    logic [31:0] rd2;
    logic [31:0] rd0;
    logic        irq2;
    logic        irq0;

    int checks = 0;
    int errors = 0;

    // Any-edge instance is the main DUT; rising-only instance shares the bus.
    soc_system_pio_in_debounced #(.WIDTH(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write(write), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2)
    );

    soc_system_pio_in_debounced #(.WIDTH(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write(write), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Select an address and let one clock edge register it.
    task automatic rd(input logic [1:0] a);
        address = a;
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write      = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
    endtask

    initial begin
        reset      = 1'b1;
        in_port    = 2'b00;
        address    = 2'd0;
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        repeat (3) @(negedge clk);
        chk("reset_readdata", rd2, 32'h0);
        chk("reset_irq", {31'b0, irq2}, 32'h0);
        reset = 1'b0;

        // Idle reads of all four registers
        rd(2'd0); chk("idle_addr0", rd2, 32'h0);
        rd(2'd1); chk("idle_addr1", rd2, 32'h0);
        rd(2'd2); chk("idle_addr2", rd2, 32'h0);
        rd(2'd3); chk("idle_addr3", rd2, 32'h0);
        chk("idle_irq", {31'b0, irq2}, 32'h0);

        // Step response on bit0: sampled at edge 1
        in_port = 2'b01;
        address = 2'd1;
        @(negedge clk);                       // edge 1
        @(negedge clk);                       // edge 2
        chk("sync_edge2", rd2, 32'h0);
        @(negedge clk);                       // edge 3
        chk("sync_edge3", rd2, 32'h1);
        address = 2'd0;
        repeat (3) @(negedge clk);            // edges 4..6
        chk("stable_edge6", rd2, 32'h0);
        @(negedge clk);                       // edge 7
        chk("stable_edge7", rd2, 32'h1);
        rd(2'd3);
        chk("step_ecap", rd2, 32'h1);
        chk("step_ecap_rise", rd0, 32'h1);
        chk("step_irq_masked", {31'b0, irq2}, 32'h0);
        wr(2'd3, 32'h3);
        rd(2'd3);
        chk("step_ecap_clr", rd2, 32'h0);

        // 3-clock glitch on bit1 is rejected
        in_port = 2'b11;
        repeat (3) @(negedge clk);
        in_port = 2'b01;
        repeat (8) @(negedge clk);
        rd(2'd0); chk("glitch_stable", rd2, 32'h1);
        rd(2'd3); chk("glitch_ecap", rd2, 32'h0);

        // 6-clock pulse on bit1 is accepted then released
        address = 2'd0;
        in_port = 2'b11;
        repeat (6) @(negedge clk);            // edges 1..6, stable[1] set at edge 6
        in_port = 2'b01;
        @(negedge clk);                       // edge 7
        chk("pulse_high", rd2, 32'h3);
        repeat (6) @(negedge clk);            // edges 8..13, stable[1] clears at edge 12
        chk("pulse_low", rd2, 32'h1);
        rd(2'd3);
        chk("pulse_ecap_any", rd2, 32'h2);
        chk("pulse_ecap_rise", rd0, 32'h2);
        wr(2'd3, 32'h3);
        rd(2'd3);
        chk("pulse_ecap_clr", rd2, 32'h0);

        // Interrupt path
        wr(2'd2, 32'h2);
        rd(2'd2);
        chk("mask_read", rd2, 32'h2);
        in_port = 2'b11;
        repeat (5) @(negedge clk);
        chk("irq_before", {31'b0, irq2}, 32'h0);
        @(negedge clk);                       // edge 6: stable[1] rises
        chk("irq_set", {31'b0, irq2}, 32'h1);
        wr(2'd3, 32'h1);
        chk("irq_hold", {31'b0, irq2}, 32'h1);
        wr(2'd3, 32'h2);
        chk("irq_clear", {31'b0, irq2}, 32'h0);

        // W1C of bit0 on the very clock bit0 falls
        in_port = 2'b10;
        repeat (5) @(negedge clk);
        address    = 2'd3;
        writedata  = 32'h1;
        chipselect = 1'b1;
        write      = 1'b1;
        @(negedge clk);                       // edge 6: fall + clear together
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        @(negedge clk);
        chk("collide_set_wins", rd2, 32'h1);
        chk("collide_fall_ignored", rd0, 32'h0);

        // Async reset in the middle of a count
        wr(2'd3, 32'h3);
        in_port = 2'b11;
        repeat (4) @(negedge clk);            // bit0 counter now 2
        address = 2'd0;
        reset = 1'b1;
        #1;
        chk("rst_mid_readdata", rd2, 32'h0);
        #1;
        reset = 1'b0;
        repeat (6) @(negedge clk);            // stable updates at edge 6
        chk("rst_edge6", rd2, 32'h0);
        @(negedge clk);
        chk("rst_edge7", rd2, 32'h3);
        rd(2'd2); chk("rst_mask", rd2, 32'h0);
        rd(2'd3); chk("rst_ecap", rd2, 32'h3);
        chk("rst_irq_masked", {31'b0, irq2}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
